// File: rtl/ramfifo_pkg.sv
// Shared types for the multi-context RAM FIFO engines.
// Holds the drain FSM encoding and the context-count helper.
package ramfifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_t;

    function automatic int num_ctx_of(input int log_ctx);
        return 1 << log_ctx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter_n #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant       = idx[IW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramfifo_ctx_drain.sv
// Read-side engine: round-robin pop of non-empty enabled contexts onto a valid/ready stream, plus per-context flush.
// Latency: FIFO head to out_valid is 1 cycle; a popped context sits out the next cycle while its empty flag catches up.
// Backpressure: no pop while out_valid is held with out_ready low; output word and context stay stable.
module ramfifo_ctx_drain
    import ramfifo_pkg::*;
#(
    parameter int WIDTH   = 36,
    parameter int LOG_CTX = 3,
    localparam int NUM_CTX = num_ctx_of(LOG_CTX)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CTX*WIDTH-1:0] fifo_dout_all,
    input  logic [NUM_CTX-1:0]       fifo_empty_all,
    output logic                     fifo_read,
    output logic [LOG_CTX-1:0]       fifo_rctx_id,
    input  logic [NUM_CTX-1:0]       ctx_enable,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [LOG_CTX-1:0]       out_ctx,
    input  logic                     out_ready,
    input  logic                     flush_req,
    input  logic [LOG_CTX-1:0]       flush_ctx,
    output logic                     flush_done,
    output logic                     busy
);

    drain_state_t         state;
    logic [LOG_CTX-1:0]   ptr;
    logic [LOG_CTX-1:0]   fctx;
    logic [LOG_CTX-1:0]   grant;
    logic [NUM_CTX-1:0]   cooldown;
    logic [NUM_CTX-1:0]   eligible;
    logic                 grant_valid;
    logic                 slot_free;
    logic                 pop_norm;
    logic                 pop_flush;
    logic                 flush_empty;

    // The empty flags lag a pop by one cycle, so the last-popped context is masked.
    assign eligible  = ~fifo_empty_all & ctx_enable & ~cooldown;
    assign slot_free = ~out_valid | out_ready;

    rr_arbiter_n #(
        .N (NUM_CTX)
    ) u_arb (
        .req         (eligible),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign pop_norm    = (state == ST_IDLE) && slot_free && grant_valid;
    assign pop_flush   = (state == ST_FLUSH) && !fifo_empty_all[fctx] && !cooldown[fctx];
    assign flush_empty = (state == ST_FLUSH) && fifo_empty_all[fctx] && !cooldown[fctx];

    assign fifo_read    = reset & (pop_norm | pop_flush);
    assign fifo_rctx_id = (state == ST_FLUSH) ? fctx : grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            fctx       <= '0;
            cooldown   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctx    <= '0;
            flush_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cooldown <= '0;
            if (fifo_read) begin
                cooldown[fifo_rctx_id] <= 1'b1;
            end

            if (pop_norm) begin
                out_valid <= 1'b1;
                out_data  <= fifo_dout_all[grant*WIDTH +: WIDTH];
                out_ctx   <= grant;
                ptr       <= grant + LOG_CTX'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    flush_done <= 1'b0;
                    if (flush_req) begin
                        fctx  <= flush_ctx;
                        state <= ST_FLUSH;
                        busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Flushed words are popped but never reach the output register.
                    if (flush_empty) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    flush_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    flush_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramfifo_ctx_drain.sv
// Directed bench for ramfifo_ctx_drain with a behavioural multi-context FIFO whose empty flags lag pops by a cycle.
module tb_ramfifo_ctx_drain;

    localparam int WIDTH   = 36;
    localparam int LOG_CTX = 3;
    localparam int NUM_CTX = 8;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_CTX*WIDTH-1:0] fifo_dout_all = '0;
    logic [NUM_CTX-1:0]       fifo_empty_all = '1;
    logic                     fifo_read;
    logic [LOG_CTX-1:0]       fifo_rctx_id;
    logic [NUM_CTX-1:0]       ctx_enable = '1;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [LOG_CTX-1:0]       out_ctx;
    logic                     out_ready = 1'b1;
    logic                     flush_req = 1'b0;
    logic [LOG_CTX-1:0]       flush_ctx = '0;
    logic                     flush_done;
    logic                     busy;

    int n_cmp = 0;
    int n_bad = 0;

    int               cnt    [NUM_CTX] = '{default: 0};
    int               hd     [NUM_CTX] = '{default: 0};
    int               rd_cnt [NUM_CTX] = '{default: 0};
    logic [WIDTH-1:0] mem    [NUM_CTX][16];
    logic             rd_q = 1'b0;
    logic [LOG_CTX-1:0] rid_q = '0;
    int               cap_ctx[$];
    logic [WIDTH-1:0] cap_dat[$];

    ramfifo_ctx_drain #(.WIDTH(WIDTH), .LOG_CTX(LOG_CTX)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_dout_all  (fifo_dout_all),
        .fifo_empty_all (fifo_empty_all),
        .fifo_read      (fifo_read),
        .fifo_rctx_id   (fifo_rctx_id),
        .ctx_enable     (ctx_enable),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ctx        (out_ctx),
        .out_ready      (out_ready),
        .flush_req      (flush_req),
        .flush_ctx      (flush_ctx),
        .flush_done     (flush_done),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic refresh();
        for (int c = 0; c < NUM_CTX; c++)
            fifo_dout_all[c*WIDTH +: WIDTH] = (cnt[c] > 0) ? mem[c][hd[c]] : '0;
    endtask

    task automatic push(input int c, input logic [WIDTH-1:0] d);
        mem[c][(hd[c] + cnt[c]) % 16] = d;
        cnt[c] = cnt[c] + 1;
        refresh();
    endtask

    // FIFO model: read sampled at the edge, flags registered from the pre-pop occupancy.
    always @(posedge clock) begin
        rd_q  <= fifo_read;
        rid_q <= fifo_rctx_id;
        for (int c = 0; c < NUM_CTX; c++)
            fifo_empty_all[c] <= (cnt[c] == 0);
        if (fifo_read) begin
            rd_cnt[fifo_rctx_id] = rd_cnt[fifo_rctx_id] + 1;
            n_cmp = n_cmp + 1;
            if (cnt[fifo_rctx_id] == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL read_of_empty: read ctx %0d holding %0d words, required non-empty", fifo_rctx_id, cnt[fifo_rctx_id]);
            end
        end
        if (out_valid && out_ready) begin
            cap_ctx.push_back(int'(out_ctx));
            cap_dat.push_back(out_data);
        end
    end

    always @(negedge clock) begin
        if (rd_q && cnt[rid_q] > 0) begin
            hd[rid_q]  = (hd[rid_q] + 1) % 16;
            cnt[rid_q] = cnt[rid_q] - 1;
        end
        refresh();
    end

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({out_valid, out_data, out_ctx} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b d=%h c=%0d, required all 0", out_valid, out_data, out_ctx);
        end
        n_cmp++;
        if ({flush_done, busy, fifo_read} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got done/busy/read=%b%b%b, required 000", flush_done, busy, fifo_read);
        end
        reset = 1'b1;
    endtask

    task automatic test_two_ctx();
        cap_ctx.delete(); cap_dat.delete();
        push(2, 36'hA); push(5, 36'hB);
        @(negedge clock);
        n_cmp++;
        if ({fifo_read, fifo_rctx_id} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL two_ctx_rd1: got rd=%b id=%0d, required rd=1 id=2", fifo_read, fifo_rctx_id);
        end
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_ctx, out_data, fifo_read, fifo_rctx_id} !== {1'b1, 3'd2, 36'hA, 1'b1, 3'd5}) begin
            n_bad++; $display("FAIL two_ctx_out1: got v=%b c=%0d d=%h rd=%b id=%0d, required 1 2 a 1 5", out_valid, out_ctx, out_data, fifo_read, fifo_rctx_id);
        end
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_ctx, out_data, fifo_read} !== {1'b1, 3'd5, 36'hB, 1'b0}) begin
            n_bad++; $display("FAIL two_ctx_out2: got v=%b c=%0d d=%h rd=%b, required 1 5 b 0", out_valid, out_ctx, out_data, fifo_read);
        end
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL two_ctx_idle: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_single_ctx_rate();
        logic [5:0] pat;
        pat = '0;
        cap_ctx.delete(); cap_dat.delete();
        push(3, 36'h31); push(3, 36'h32); push(3, 36'h33);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            pat[5-k] = fifo_read;
        end
        n_cmp++;
        if (pat !== 6'b101010) begin
            n_bad++; $display("FAIL rate_pattern: got %b, required 101010", pat);
        end
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 36'h33}) begin
            n_bad++; $display("FAIL rate_third_word: got v=%b d=%h, required 1 33", out_valid, out_data);
        end
        @(negedge clock);
        n_cmp++;
        if (cap_dat.size() != 3 || cap_dat[0] !== 36'h31 || cap_dat[1] !== 36'h32 || cap_dat[2] !== 36'h33 || cap_ctx[2] != 3) begin
            n_bad++; $display("FAIL rate_order: got %0d words, required 31 32 33 from ctx 3", cap_dat.size());
        end
    endtask

    task automatic test_backpressure();
        int r0;
        int stable_bad;
        stable_bad = 0;
        cap_ctx.delete(); cap_dat.delete();
        out_ready = 1'b0;
        r0 = rd_cnt[1];
        push(1, 36'h11); push(1, 36'h12);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if ({out_valid, out_ctx, out_data} !== {1'b1, 3'd1, 36'h11}) stable_bad++;
        end
        n_cmp++;
        if (stable_bad != 0) begin
            n_bad++; $display("FAIL bp_stable: %0d unstable cycles, required 0", stable_bad);
        end
        n_cmp++;
        if (rd_cnt[1] - r0 != 1) begin
            n_bad++; $display("FAIL bp_one_pop: got %0d pops, required 1", rd_cnt[1] - r0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 36'h12}) begin
            n_bad++; $display("FAIL bp_second: got v=%b d=%h, required 1 12", out_valid, out_data);
        end
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0 || cap_dat.size() != 2 || cap_dat[0] !== 36'h11) begin
            n_bad++; $display("FAIL bp_drain: got v=%b n=%0d, required 0 2", out_valid, cap_dat.size());
        end
    endtask

    task automatic test_enable_mask();
        int r0;
        int seen;
        seen = 0;
        ctx_enable = 8'b1111_1011;
        r0 = rd_cnt[2];
        push(2, 36'h22);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (out_valid || (fifo_read && fifo_rctx_id == 3'd2)) seen++;
        end
        n_cmp++;
        if (seen != 0 || rd_cnt[2] != r0) begin
            n_bad++; $display("FAIL mask_blocks: got %0d active cycles and %0d reads, required 0", seen, rd_cnt[2] - r0);
        end
        ctx_enable = '1;
        #1;
        n_cmp++;
        if ({fifo_read, fifo_rctx_id} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL mask_release_rd: got rd=%b id=%0d, required 1 2", fifo_read, fifo_rctx_id);
        end
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_ctx, out_data} !== {1'b1, 3'd2, 36'h22}) begin
            n_bad++; $display("FAIL mask_release_out: got v=%b c=%0d d=%h, required 1 2 22", out_valid, out_ctx, out_data);
        end
        @(negedge clock);
    endtask

    task automatic test_flush();
        int r0;
        int busy_bad;
        int dk;
        busy_bad = 0;
        dk = -1;
        ctx_enable = 8'b1110_1111;
        push(4, 36'h41); push(4, 36'h42); push(4, 36'h43);
        @(negedge clock);
        r0 = rd_cnt[4];
        cap_ctx.delete(); cap_dat.delete();
        flush_req = 1'b1; flush_ctx = 3'd4;
        @(negedge clock);
        flush_req = 1'b0;
        if (busy !== 1'b1) busy_bad++;
        for (int k = 3; k < 23; k++) begin
            @(negedge clock);
            if (flush_done === 1'b1) begin
                dk = k;
                if (busy !== 1'b1) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        n_cmp++;
        if (dk != 9) begin
            n_bad++; $display("FAIL flush_done_time: got cycle %0d, required 9", dk);
        end
        n_cmp++;
        if (rd_cnt[4] - r0 != 3 || cap_dat.size() != 0) begin
            n_bad++; $display("FAIL flush_discard: got %0d reads %0d outputs, required 3 0", rd_cnt[4] - r0, cap_dat.size());
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_bad++; $display("FAIL flush_busy: %0d cycles busy low, required 0", busy_bad);
        end
        @(negedge clock);
        n_cmp++;
        if ({flush_done, busy} !== 2'b00) begin
            n_bad++; $display("FAIL flush_exit: got done/busy=%b%b, required 00", flush_done, busy);
        end
        ctx_enable = '1;
    endtask

    task automatic test_flush_empty();
        flush_req = 1'b1; flush_ctx = 3'd6;
        @(negedge clock);
        flush_req = 1'b0;
        n_cmp++;
        if ({flush_done, busy} !== 2'b01) begin
            n_bad++; $display("FAIL flush_empty_c1: got done/busy=%b%b, required 01", flush_done, busy);
        end
        @(negedge clock);
        n_cmp++;
        if ({flush_done, busy} !== 2'b11) begin
            n_bad++; $display("FAIL flush_empty_c2: got done/busy=%b%b, required 11", flush_done, busy);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_flush();
        ctx_enable = 8'b1110_1111;
        out_ready = 1'b0;
        push(7, 36'h77);
        push(4, 36'h44); push(4, 36'h45); push(4, 36'h46);
        @(negedge clock);
        flush_req = 1'b1; flush_ctx = 3'd4;
        @(negedge clock);
        flush_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_ctx, busy, fifo_read} !== {1'b1, 3'd7, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL midflush_pre: got v=%b c=%0d busy=%b rd=%b, required 1 7 1 1", out_valid, out_ctx, busy, fifo_read);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_ctx, busy, flush_done, fifo_read} !== '0) begin
            n_bad++; $display("FAIL midflush_async: got v=%b d=%h c=%0d busy=%b done=%b rd=%b, required all 0", out_valid, out_data, out_ctx, busy, flush_done, fifo_read);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ctx_enable = '1;
        out_ready = 1'b1;
        push(0, 36'h50);
        @(negedge clock);
        n_cmp++;
        if ({fifo_read, fifo_rctx_id, busy, flush_done} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL resume_rd: got rd=%b id=%0d busy=%b done=%b, required 1 0 0 0", fifo_read, fifo_rctx_id, busy, flush_done);
        end
        @(negedge clock);
        n_cmp++;
        if ({out_valid, out_ctx, out_data, fifo_rctx_id} !== {1'b1, 3'd0, 36'h50, 3'd4}) begin
            n_bad++; $display("FAIL resume_out: got v=%b c=%0d d=%h next=%0d, required 1 0 50 4", out_valid, out_ctx, out_data, fifo_rctx_id);
        end
        repeat (6) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_two_ctx();
        test_single_ctx_rate();
        test_backpressure();
        test_enable_mask();
        test_flush();
        test_flush_empty();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
